// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game flow controller.
//   - screen/state codes (4-bit, legacy numeric encoding)
//   - decoded keyboard scan codes (bit [8] is the extended-code flag)
//   - per-stage start coordinates for player and key
//   - small helpers for clamped movement and overlap distance
package game_pkg;

  localparam logic [3:0] ST_TITLE  = 4'd0;
  localparam logic [3:0] ST_STAGE1 = 4'd1;
  localparam logic [3:0] ST_SUCC1  = 4'd2;
  localparam logic [3:0] ST_STAGE2 = 4'd3;
  localparam logic [3:0] ST_SUCC2  = 4'd4;
  localparam logic [3:0] ST_STAGE3 = 4'd5;
  localparam logic [3:0] ST_SUCC3  = 4'd6;
  localparam logic [3:0] ST_FAIL3  = 4'd7;
  localparam logic [3:0] ST_STAFF  = 4'd8;

  localparam logic [8:0] KC_RSHIFT = 9'h059;
  localparam logic [8:0] KC_1      = 9'h069;
  localparam logic [8:0] KC_2      = 9'h072;
  localparam logic [8:0] KC_3      = 9'h07A;
  localparam logic [8:0] KC_W      = 9'h01D;
  localparam logic [8:0] KC_A      = 9'h01C;
  localparam logic [8:0] KC_S      = 9'h01B;
  localparam logic [8:0] KC_D      = 9'h023;
  localparam logic [8:0] KC_N      = 9'h031;
  localparam logic [8:0] KC_B      = 9'h032;
  localparam logic [8:0] KC_R      = 9'h02D;

  typedef struct packed {
    logic [8:0] px;
    logic [8:0] py;
    logic [8:0] kx;
    logic [8:0] ky;
  } stage_start_t;

  localparam stage_start_t START_STAGE1 = '{px: 9'd0,   py: 9'd0,   kx: 9'd288, ky: 9'd208};
  localparam stage_start_t START_STAGE2 = '{px: 9'd304, py: 9'd0,   kx: 9'd16,  ky: 9'd224};
  localparam stage_start_t START_STAGE3 = '{px: 9'd144, py: 9'd224, kx: 9'd144, ky: 9'd0};

  // Move toward 0 by step, saturating at 0.
  function automatic logic [8:0] step_down(input logic [8:0] v, input logic [8:0] step);
    return (v < step) ? 9'd0 : v - step;
  endfunction

  // Move away from 0 by step, saturating at max; the sum is formed in
  // 10 bits so a wrap past 511 can never look like a small value.
  function automatic logic [8:0] step_up(input logic [8:0] v, input logic [8:0] step,
                                         input logic [8:0] max);
    logic [9:0] sum;
    sum = {1'b0, v} + {1'b0, step};
    return (sum > {1'b0, max}) ? max : sum[8:0];
  endfunction

  function automatic logic [9:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
  endfunction

endpackage

// File: rtl/game_flow_ctrl_stage_timer.sv
// stage_timer: loadable 32-bit down-counter used as the stage-3 clock.
//   clk, rst        clock, asynchronous active-low reset
//   load, load_value  load count with load_value (wins over en)
//   clear           force count to 0 (wins over everything)
//   en              decrement by 1 while count is nonzero
//   count, zero     current value and count==0 flag
module stage_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] load_value,
  output logic [31:0] count,
  output logic        zero
);

  assign zero = (count == 32'd0);

  // NOTE: state registers use non-blocking (<=) assignments and an async
  // active-low reset in the sensitivity list; blocking assignments here
  // would create simulation/synthesis ordering mismatches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 32'd0;
    end else if (clear) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !zero) begin
      count <= count - 32'd1;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: screen sequencer for the game.
//   clk, rst       clock, asynchronous active-low reset
//   key_valid      one-cycle strobe for a decoded keyboard event
//   key_code       scan code (bit [8] = extended)
//   key_make       1 = press, 0 = release
//   state          current screen (TITLE..STAFF, see game_pkg)
//   player_x/y     player sprite position
//   key_x/y        key sprite position
//   time_left      remaining stage-3 cycles, 0 elsewhere
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [8:0]  STEP       = 9'd16,
  parameter logic [8:0]  X_MAX      = 9'd304,
  parameter logic [8:0]  Y_MAX      = 9'd224,
  parameter logic [8:0]  HIT        = 9'd16,
  parameter logic [31:0] TIME_LIMIT = 32'd1_500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [8:0]  key_code,
  input  logic        key_make,
  output logic [3:0]  state,
  output logic [8:0]  player_x,
  output logic [8:0]  player_y,
  output logic [8:0]  key_x,
  output logic [8:0]  key_y,
  output logic [31:0] time_left
);

  logic         press;
  logic         in_stage;
  logic         hit;
  logic         expire;
  logic         move_en;
  logic         enter_stage;
  logic [3:0]   next_state;
  logic         timer_zero;
  stage_start_t start;

  // Only make events drive the game; releases never do anything.
  assign press    = key_valid && key_make;
  assign in_stage = (state == ST_STAGE1) || (state == ST_STAGE2) || (state == ST_STAGE3);

  // Overlap is judged on the registered positions, so a winning move is
  // seen one edge after it lands.
  assign hit = in_stage
            && (abs_diff(player_x, key_x) < {1'b0, HIT})
            && (abs_diff(player_y, key_y) < {1'b0, HIT});

  // Expire on the edge where the counter reaches 0 (count is 1 now), or if
  // it is already 0 (e.g. a zero time budget).
  assign expire = (state == ST_STAGE3) && (timer_zero || (time_left == 32'd1));

  // NOTE: every signal written in this always_comb gets a default first,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    move_en    = 1'b0;
    case (state)
      ST_TITLE: begin
        if (press && (key_code == KC_RSHIFT || key_code == KC_1)) next_state = ST_STAGE1;
        else if (press && key_code == KC_2)                       next_state = ST_STAGE2;
        else if (press && key_code == KC_3)                       next_state = ST_STAGE3;
      end
      ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
        // Each SUCCn code is its STAGEn code plus one.
        if (hit)                              next_state = state + 4'd1;
        else if (expire)                      next_state = ST_FAIL3;
        else if (press && key_code == KC_B)   next_state = ST_TITLE;
        else                                  move_en    = 1'b1;
      end
      ST_SUCC1: begin
        if (press && key_code == KC_B)        next_state = ST_TITLE;
        else if (press && key_code == KC_N)   next_state = ST_STAGE2;
      end
      ST_SUCC2: begin
        if (press && key_code == KC_B)        next_state = ST_TITLE;
        else if (press && key_code == KC_N)   next_state = ST_STAGE3;
      end
      ST_SUCC3: begin
        if (press && key_code == KC_B)        next_state = ST_TITLE;
        else if (press && key_code == KC_N)   next_state = ST_STAFF;
      end
      ST_FAIL3: begin
        if (press && key_code == KC_B)        next_state = ST_TITLE;
        else if (press && key_code == KC_R)   next_state = ST_STAGE3;
      end
      ST_STAFF: begin
        if (press && (key_code == KC_N || key_code == KC_B)) next_state = ST_TITLE;
      end
      default: next_state = ST_TITLE;
    endcase
  end

  // A stage is (re)entered whenever the next screen is a stage the FSM is
  // not already in; this covers the FAIL3 -> STAGE3 retry.
  assign enter_stage = (next_state != state)
                    && ((next_state == ST_STAGE1) || (next_state == ST_STAGE2)
                        || (next_state == ST_STAGE3));

  always_comb begin
    case (next_state)
      ST_STAGE2: start = START_STAGE2;
      ST_STAGE3: start = START_STAGE3;
      default:   start = START_STAGE1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_TITLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player_x <= 9'd0;
      player_y <= 9'd0;
      key_x    <= 9'd0;
      key_y    <= 9'd0;
    end else if (enter_stage) begin
      player_x <= start.px;
      player_y <= start.py;
      key_x    <= start.kx;
      key_y    <= start.ky;
    end else if (move_en && press) begin
      case (key_code)
        KC_W:    player_y <= step_down(player_y, STEP);
        KC_S:    player_y <= step_up(player_y, STEP, Y_MAX);
        KC_A:    player_x <= step_down(player_x, STEP);
        KC_D:    player_x <= step_up(player_x, STEP, X_MAX);
        default: ;
      endcase
    end
  end

  stage_timer u_stage3_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (enter_stage && (next_state == ST_STAGE3)),
    .en         (state == ST_STAGE3),
    .clear      (next_state != ST_STAGE3),
    .load_value (TIME_LIMIT),
    .count      (time_left),
    .zero       (timer_zero)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed self-checking bench for game_flow_ctrl.
// Expected output snapshots are queued as each step is driven and compared
// against the DUT half a clock after the sampling edge.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [8:0]  key_code = 9'd0;
  logic        key_make = 1'b0;
  logic [3:0]  state;
  logic [8:0]  player_x, player_y, key_x, key_y;
  logic [31:0] time_left;

  localparam logic [31:0] TL = 32'd20;

  game_flow_ctrl #(.TIME_LIMIT(TL)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_make  (key_make),
    .state     (state),
    .player_x  (player_x),
    .player_y  (player_y),
    .key_x     (key_x),
    .key_y     (key_y),
    .time_left (time_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [8:0]  px, py, kx, ky;
    logic [31:0] tl;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic expect_snap(input string tag, input logic [3:0] st, input logic [8:0] px,
                             input logic [8:0] py, input logic [8:0] kx, input logic [8:0] ky,
                             input logic [31:0] tl);
    snap_t s;
    s.tag = tag; s.st = st; s.px = px; s.py = py; s.kx = kx; s.ky = ky; s.tl = tl;
    sb.push_back(s);
  endtask

  task automatic compare();
    snap_t s;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    s = sb.pop_front();
    check({s.tag, ".state"},     {28'd0, state},    {28'd0, s.st});
    check({s.tag, ".player_x"},  {23'd0, player_x}, {23'd0, s.px});
    check({s.tag, ".player_y"},  {23'd0, player_y}, {23'd0, s.py});
    check({s.tag, ".key_x"},     {23'd0, key_x},    {23'd0, s.kx});
    check({s.tag, ".key_y"},     {23'd0, key_y},    {23'd0, s.ky});
    check({s.tag, ".time_left"}, time_left,         s.tl);
  endtask

  // Called at a negedge: presents one event for the next posedge, returns at
  // the following negedge with key_valid low again.
  task automatic key_event(input logic [8:0] code, input logic make);
    key_valid = 1'b1;
    key_code  = code;
    key_make  = make;
    @(negedge clk);
    key_valid = 1'b0;
    key_make  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int ex;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_snap("reset", 4'd0, 9'd0, 9'd0, 9'd0, 9'd0, 32'd0);
    compare();

    // TITLE -> STAGE1, release and unrelated codes ignored
    expect_snap("rshift_make", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h059, 1'b1); compare();
    expect_snap("rshift_break", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h059, 1'b0); compare();
    expect_snap("digit2_in_stage", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h072, 1'b1); compare();

    // Clamp at the low edges
    expect_snap("a_at_0", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h01C, 1'b1); compare();
    expect_snap("w_at_0", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h01D, 1'b1); compare();

    // Clamp at X_MAX
    for (int i = 1; i <= 20; i++) begin
      ex = (16 * i > 304) ? 304 : 16 * i;
      expect_snap($sformatf("d_%0d", i), 4'd1, 9'(ex), 9'd0, 9'd288, 9'd208, 32'd0);
      key_event(9'h023, 1'b1); compare();
    end
    expect_snap("b_to_title", 4'd0, 9'd304, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h032, 1'b1); compare();

    // Walk onto the key: hit appears one edge after landing
    expect_snap("reenter_s1", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h069, 1'b1); compare();
    for (int i = 1; i <= 18; i++) begin
      expect_snap($sformatf("walk_d_%0d", i), 4'd1, 9'(16 * i), 9'd0, 9'd288, 9'd208, 32'd0);
      key_event(9'h023, 1'b1); compare();
    end
    for (int i = 1; i <= 13; i++) begin
      expect_snap($sformatf("walk_s_%0d", i), 4'd1, 9'd288, 9'(16 * i), 9'd288, 9'd208, 32'd0);
      key_event(9'h01B, 1'b1); compare();
    end
    expect_snap("succ1", 4'd2, 9'd288, 9'd208, 9'd288, 9'd208, 32'd0);
    idle(1); compare();
    expect_snap("n_to_s2", 4'd3, 9'd304, 9'd0, 9'd16, 9'd224, 32'd0);
    key_event(9'h031, 1'b1); compare();
    expect_snap("s2_b", 4'd0, 9'd304, 9'd0, 9'd16, 9'd224, 32'd0);
    key_event(9'h032, 1'b1); compare();

    // Stage 3 timeout and retry
    expect_snap("enter_s3", 4'd5, 9'd144, 9'd224, 9'd144, 9'd0, TL);
    key_event(9'h07A, 1'b1); compare();
    expect_snap("s3_tl1", 4'd5, 9'd144, 9'd224, 9'd144, 9'd0, 32'd1);
    idle(19); compare();
    expect_snap("fail3", 4'd7, 9'd144, 9'd224, 9'd144, 9'd0, 32'd0);
    idle(1); compare();
    expect_snap("fail3_hold", 4'd7, 9'd144, 9'd224, 9'd144, 9'd0, 32'd0);
    idle(2); compare();
    expect_snap("retry_r", 4'd5, 9'd144, 9'd224, 9'd144, 9'd0, TL);
    key_event(9'h02D, 1'b1); compare();

    // Hit lands together with expiry -> SUCC3 wins
    expect_snap("s3_tl15", 4'd5, 9'd144, 9'd224, 9'd144, 9'd0, 32'd15);
    idle(5); compare();
    for (int i = 1; i <= 14; i++) begin
      expect_snap($sformatf("s3_w_%0d", i), 4'd5, 9'd144, 9'(224 - 16 * i), 9'd144, 9'd0,
                  32'(15 - i));
      key_event(9'h01D, 1'b1); compare();
    end
    expect_snap("succ3_over_fail", 4'd6, 9'd144, 9'd0, 9'd144, 9'd0, 32'd0);
    idle(1); compare();
    expect_snap("staff", 4'd8, 9'd144, 9'd0, 9'd144, 9'd0, 32'd0);
    key_event(9'h031, 1'b1); compare();
    expect_snap("staff_b", 4'd0, 9'd144, 9'd0, 9'd144, 9'd0, 32'd0);
    key_event(9'h032, 1'b1); compare();

    // Async reset in the middle of stage 2
    expect_snap("enter_s2", 4'd3, 9'd304, 9'd0, 9'd16, 9'd224, 32'd0);
    key_event(9'h072, 1'b1); compare();
    for (int i = 1; i <= 9; i++) begin
      expect_snap($sformatf("s2_a_%0d", i), 4'd3, 9'(304 - 16 * i), 9'd0, 9'd16, 9'd224, 32'd0);
      key_event(9'h01C, 1'b1); compare();
    end
    for (int i = 1; i <= 6; i++) begin
      expect_snap($sformatf("s2_s_%0d", i), 4'd3, 9'd160, 9'(16 * i), 9'd16, 9'd224, 32'd0);
      key_event(9'h01B, 1'b1); compare();
    end
    #2 rst = 1'b0;
    expect_snap("async_reset", 4'd0, 9'd0, 9'd0, 9'd0, 9'd0, 32'd0);
    #1 compare();
    @(negedge clk);
    rst = 1'b1;
    expect_snap("reset_release", 4'd0, 9'd0, 9'd0, 9'd0, 9'd0, 32'd0);
    idle(1); compare();
    expect_snap("after_reset_start", 4'd1, 9'd0, 9'd0, 9'd288, 9'd208, 32'd0);
    key_event(9'h059, 1'b1); compare();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
